sto2bin: RTL
============

# sto2bin

Stochastic-to-binary decoder: accumulates a unipolar bitstream over a fixed window of 2^WIDTH accepted bits and returns the ones-count as a binary word through a valid/ready handshake. It sits at the output end of a stochastic datapath, behind blocks such as the stochastic ReLU, and turns the result stream back into a binary value for readout or the next layer.

## Interface
- WIDTH, 8, window exponent; window length N = 2^WIDTH accepted bits; legal range 2..16.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin a new accumulation window.
- in_valid  input  1  `in` carries a stream bit this cycle.
- in  input  1  stochastic bitstream bit.
- busy  output  1  high in ACCUM.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH+1  result word; encoding set by configuration.

## Operation
- FSM states: IDLE, ACCUM, DONE. Reset enters IDLE.
- IDLE: start=1 -> ACCUM; clear the ones counter and the bit counter.
- ACCUM: each cycle with in_valid=1, the bit counter increments by 1 and the ones counter increments by `in`. Cycles with in_valid=0 change nothing.
- When the N-th valid bit is accepted, move to DONE. Register the result, including that last bit, into out_data.
- Bit counter is WIDTH+1 bits wide and ends at exactly N. Ones counter is WIDTH+1 bits, ranges 0..N, and never wraps or saturates.
- start=1 in ACCUM aborts the window: both counters clear and ACCUM continues. A valid bit in that same cycle is counted as bit 1 of the new window.
- DONE: out_valid=1. out_data is stable until out_valid=1 and out_ready=1 in the same cycle (handshake).
- Handshake with start=0 -> IDLE. Handshake with start=1 -> ACCUM with cleared counters.
- start in DONE without a handshake is ignored.
- in_valid outside ACCUM is ignored.
- Reset mid-window discards the partial count. No result is emitted.

## Timing
- Reset values: busy=0, out_valid=0, out_data=0. Internal counters are 0.
- start sampled at edge t in IDLE -> busy=1 from t+1. The first bit can be accepted at edge t+1.
- Last valid bit accepted at edge k -> out_valid=1 and busy=0 from k+1. That is one cycle of latency.
- With continuous in_valid, start-to-out_valid is N+1 cycles.
- Minimum spacing between results is N+1 cycles: handshake-with-start at edge h gives ACCUM at h+1.
- out_valid falls in the cycle after the handshake edge.
- out_ready is ignored when out_valid=0.

## Configuration
- STO2BIN_BIPOLAR_EN defined: out_data is the two's-complement value ones − N/2, range −N/2..+N/2. This represents the bipolar value x·N/2.
- STO2BIN_BIPOLAR_EN undefined: out_data is the unsigned ones-count, range 0..N.
- Counters, FSM and timing are identical in both modes. Only the output register input differs.

## Structure
- Package sto2bin_pkg holds:
  - typedef enum for the FSM states (IDLE, ACCUM, DONE);
  - a function converting a ones-count to the bipolar offset form, parameterised by WIDTH.
- One sub-module, win_counter, is natural. It holds the paired bit/ones counters with clear, enable (in_valid & ACCUM) and a terminal flag (bit count = N−1 with enable).
- The top level holds the FSM, the output register and the handshake.

## Test plan
- WIDTH=4, unipolar:
  - start, then 16 bits in=1 with in_valid=1 -> out_valid at cycle 17, out_data=16.
  - Alternating 1/0 for 16 bits -> out_data=8.
  - All 16 bits 0 -> out_data=0.
- Gaps: 16 ones interleaved with 10 in_valid=0 cycles that have in=1 -> out_data=16, out_valid 27 cycles after start.
- Backpressure and abort:
  - Hold out_ready=0 for 5 cycles after DONE, with start pulses in between -> out_data stable, no new window; out_ready=1 -> IDLE.
  - start after 7 bits in ACCUM, then 16 ones -> out_data=16.
  - Handshake plus start in the same cycle -> busy=1 next cycle, second result correct.
- STO2BIN_BIPOLAR_EN, WIDTH=4:
  - 16 ones -> +8.
  - 16 zeros -> −8 (5'b11000).
  - 8 ones -> 0.
  - Reset asserted mid-window -> out_valid=0, busy=0, out_data=0 immediately.

Source files
------------

// File: rtl/sto2bin_pkg.sv
// rtl/sto2bin_pkg.sv - shared types and helpers for the stochastic-to-binary decoder
//
// Contents:
//   state_t     FSM states IDLE, ACCUM, DONE
//   MAX_WIDTH   largest supported window exponent
//   to_bipolar  ones-count -> two's-complement offset (ones - N/2), N = 2^width

package sto2bin_pkg;

    localparam int unsigned MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The result is carried at the widest supported size.
    // Callers keep the low width+1 bits, which are the exact two's-complement
    // value because the result always lies in -N/2..+N/2.
    function automatic logic [MAX_WIDTH:0] to_bipolar(
        input logic [MAX_WIDTH:0] ones,
        input int unsigned        width
    );
        logic [MAX_WIDTH:0] half;
        half = (MAX_WIDTH+1)'(1) << (width - 1);
        return ones - half;
    endfunction

endpackage

// File: rtl/sto2bin_win_counter.sv
// rtl/sto2bin_win_counter.sv - paired bit/ones counters for one accumulation window
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       restart the window (a bit enabled in the same cycle becomes bit 1)
//   en          accept bit_in this cycle
//   bit_in      stream bit
//   ones_cnt    ones counted so far in the window (0..N)
//   terminal    the bit being accepted now is the N-th of the window

module win_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    output logic [WIDTH:0]   ones_cnt,
    output logic             terminal
);

    localparam logic [WIDTH:0] LAST_IDX = {1'b0, {WIDTH{1'b1}}};

    logic [WIDTH:0] bit_cnt;
    logic [WIDTH:0] bit_ext;

    assign bit_ext = {{WIDTH{1'b0}}, bit_in};

    // A clearing cycle restarts at bit 1, so it can never be the N-th bit.
    assign terminal = en && !clear && (bit_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
        end else if (clear) begin
            bit_cnt  <= en ? {{WIDTH{1'b0}}, 1'b1} : '0;
            ones_cnt <= en ? bit_ext : '0;
        end else if (en) begin
            bit_cnt  <= bit_cnt + {{WIDTH{1'b0}}, 1'b1};
            ones_cnt <= ones_cnt + bit_ext;
        end
    end

endmodule

// File: rtl/sto2bin.sv
// rtl/sto2bin.sv - stochastic-to-binary decoder with valid/ready result output
//
// Counts the ones in a window of N = 2^WIDTH accepted stream bits and presents
// the count on out_data with a valid/ready handshake.
// Build option: STO2BIN_BIPOLAR_EN selects out_data = ones - N/2 (two's
// complement); otherwise out_data is the unsigned ones-count.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       begin (or restart) a window
//   in_valid    in carries a stream bit this cycle
//   in          stream bit
//   busy        accumulating
//   out_valid   out_data holds a completed result
//   out_ready   consumer accepts out_data
//   out_data    result word, WIDTH+1 bits

module sto2bin
    import sto2bin_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in,
    output logic             busy,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH:0]   out_data
);

    state_t         state;
    state_t         state_next;
    logic           clear;
    logic           count_en;
    logic           terminal;
    logic [WIDTH:0] ones_cnt;
    logic [WIDTH:0] ones_final;
    logic [WIDTH:0] result_d;

    assign count_en = in_valid && (state == ACCUM);

    win_counter #(
        .WIDTH (WIDTH)
    ) u_win_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .en       (count_en),
        .bit_in   (in),
        .ones_cnt (ones_cnt),
        .terminal (terminal)
    );

    // The counter register has not yet absorbed the last bit when terminal
    // fires, so fold it in here.
    assign ones_final = ones_cnt + {{WIDTH{1'b0}}, in};

`ifdef STO2BIN_BIPOLAR_EN
    assign result_d = (WIDTH+1)'(to_bipolar((MAX_WIDTH+1)'(ones_final), WIDTH));
`else
    assign result_d = ones_final;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCUM;
                    clear      = 1'b1;
                end
            end
            ACCUM: begin
                if (start) begin
                    clear = 1'b1;
                end else if (terminal) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // start without a handshake is ignored so the held result
                // cannot be overwritten before it is consumed.
                if (out_ready) begin
                    if (start) begin
                        state_next = ACCUM;
                        clear      = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (terminal && state == ACCUM) begin
            out_data <= result_d;
        end
    end

    assign busy      = (state == ACCUM);
    assign out_valid = (state == DONE);

endmodule
